// File: rtl/rv32i_types.sv
// Shared core types: the CDB result record plus the CDB arbiter's source map and defaults.
// Pure declarations, no timing or flow-control behaviour.
package rv32i_types;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rob_idx;
    logic [5:0]  pd_s;
    logic [31:0] rd_v;
  } cdb_t;

  localparam int CDB_NUM_SRC    = 4;
  localparam int CDB_SRC_ADD    = 0;
  localparam int CDB_SRC_MUL    = 1;
  localparam int CDB_SRC_DIV    = 2;
  localparam int CDB_SRC_BR     = 3;
  localparam int CDB_FIFO_DEPTH = 8;
  localparam int CDB_HOLD_SLACK = 5;

  // Returns {found, index} of the first set bit at or after ptr, wrapping mod 4.
  function automatic logic [2:0] cdb_rr_pick(input logic [3:0] nonempty, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (nonempty[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Bundle of the CDB arbiter's data-path signals: four FU results in, one CDB result out.
// Holds are level signals to issue; there is no handshake on the inputs.
interface cdb_arbiter_if;
  import rv32i_types::*;

  logic global_branch_signal;
  cdb_t cdb_add_in;
  cdb_t cdb_mul_in;
  cdb_t cdb_div_in;
  cdb_t cdb_br_in;
  cdb_t cdb_out;
  logic hold_add;
  logic hold_mul;
  logic hold_div;
  logic hold_br;
  logic overflow_err;

  modport master (
    output global_branch_signal, cdb_add_in, cdb_mul_in, cdb_div_in, cdb_br_in,
    input  cdb_out, hold_add, hold_mul, hold_div, hold_br, overflow_err
  );

  modport slave (
    input  global_branch_signal, cdb_add_in, cdb_mul_in, cdb_div_in, cdb_br_in,
    output cdb_out, hold_add, hold_mul, hold_div, hold_br, overflow_err
  );

endinterface

// File: rtl/cdb_fifo.sv
// Per-source result FIFO; head is combinational from storage, count updates at the edge.
// A push into a full FIFO is still accepted when the head is popped the same cycle; flush empties it.
module cdb_fifo
  import rv32i_types::*;
#(
  parameter  int DEPTH = CDB_FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  cdb_t          push_data,
  input  logic          pop,
  output cdb_t          head,
  output logic [CW-1:0] count,
  output logic          accept
);

  cdb_t          mem [DEPTH];
  logic [AW-1:0] head_ptr;
  logic [AW-1:0] tail_ptr;
  logic          do_pop;

  assign do_pop = pop && !flush && (count != '0);
  assign accept = push && !flush && ((count < CW'(DEPTH)) || do_pop);
  assign head   = mem[head_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (accept) tail_ptr <= tail_ptr + 1'b1;
      if (do_pop) head_ptr <= head_ptr + 1'b1;
      if (accept && !do_pop)      count <= count + 1'b1;
      else if (!accept && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[tail_ptr] <= push_data;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Buffers four FU results and grants one per cycle round-robin onto the CDB (push N, earliest out N+1).
// No input backpressure: issue is throttled by hold_*, overflowing pushes are dropped and flagged.
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int FIFO_DEPTH = CDB_FIFO_DEPTH,
  parameter int HOLD_SLACK = CDB_HOLD_SLACK
) (
  input logic         clk,
  input logic         rst,
  cdb_arbiter_if.slave bus
);

  localparam int            CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] HOLD_TH = CW'(FIFO_DEPTH - HOLD_SLACK);

  cdb_t                   in_arr    [CDB_NUM_SRC];
  cdb_t                   head_arr  [CDB_NUM_SRC];
  logic [CW-1:0]          count_arr [CDB_NUM_SRC];
  logic [CDB_NUM_SRC-1:0] push_v;
  logic [CDB_NUM_SRC-1:0] accept_v;
  logic [CDB_NUM_SRC-1:0] pop_v;
  logic [CDB_NUM_SRC-1:0] nonempty;
  logic [1:0]             rr_ptr;
  logic [1:0]             winner;
  logic [2:0]             pick;
  logic                   grant;
  logic                   flush;
  logic                   overflow_q;
  cdb_t                   cdb_out_c;

  assign flush                = bus.global_branch_signal;
  assign in_arr[CDB_SRC_ADD]  = bus.cdb_add_in;
  assign in_arr[CDB_SRC_MUL]  = bus.cdb_mul_in;
  assign in_arr[CDB_SRC_DIV]  = bus.cdb_div_in;
  assign in_arr[CDB_SRC_BR]   = bus.cdb_br_in;

  for (genvar g = 0; g < CDB_NUM_SRC; g++) begin : g_src
    assign push_v[g]   = in_arr[g].valid;
    assign nonempty[g] = (count_arr[g] != '0);

    cdb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (push_v[g]),
      .push_data (in_arr[g]),
      .pop       (pop_v[g]),
      .head      (head_arr[g]),
      .count     (count_arr[g]),
      .accept    (accept_v[g])
    );
  end

  always_comb begin
    pick      = cdb_rr_pick(nonempty, rr_ptr);
    grant     = pick[2] && !flush;
    winner    = pick[1:0];
    pop_v     = '0;
    cdb_out_c = '0;
    if (grant) begin
      pop_v[winner]   = 1'b1;
      cdb_out_c       = head_arr[winner];
      cdb_out_c.valid = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (grant) rr_ptr <= winner + 2'd1;
      // Flushed inputs are discarded on purpose and must not look like overflow.
      if (!flush && |(push_v & ~accept_v)) overflow_q <= 1'b1;
    end
  end

  assign bus.cdb_out      = cdb_out_c;
  assign bus.hold_add     = !rst && (count_arr[CDB_SRC_ADD] >= HOLD_TH);
  assign bus.hold_mul     = !rst && (count_arr[CDB_SRC_MUL] >= HOLD_TH);
  assign bus.hold_div     = !rst && (count_arr[CDB_SRC_DIV] >= HOLD_TH);
  assign bus.hold_br      = !rst && (count_arr[CDB_SRC_BR]  >= HOLD_TH);
  assign bus.overflow_err = overflow_q;

endmodule
